// File: rtl/rotfpga_cfg_loader.sv
// rotfpga_cfg_loader
// ------------------
// Configuration sequencer for the rotating-tile FPGA grid. Takes a bitstream
// as bytes over a valid/ready handshake, pulses the grid reset, then shifts
// CHAIN_LEN bits (LSB of each byte first) through the grid scan chain. Each
// bit costs two cycles (grid_clk low, then high). The grid samples on the
// rising edge of grid_clk. Afterwards the grid is returned to user mode.
//
// Parameters:
//   CHAIN_LEN  - scan-chain bits shifted per load (>= 1)
//   RST_CYCLES - cycles grid_rst_n is held low at the start of a load (>= 1)
//
// Ports:
//   clk, rst             - system clock, asynchronous active-high reset
//   start                - one-cycle load request (ignored while busy)
//   abort                - synchronous abort of a load in progress
//   cfg_mode[1:0]        - latched onto grid_cfg when a load starts
//   byte_data/valid/ready- bitstream byte handshake
//   grid_clk, grid_rst_n, grid_se, grid_sc, grid_cfg - grid control pins
//   grid_sc_out          - grid scan-chain output (readback)
//   busy                 - load in progress
//   done                 - one-cycle pulse on successful completion
//   bit_count[15:0]      - bits shifted in the current load (saturates)
//   rb_crc[7:0]          - CRC-8 of the readback stream
//
// Optional feature: define ROTFPGA_CFG_READBACK_EN to fold grid_sc_out into
// rb_crc (CRC-8, poly 0x07, init 0x00) on every grid_clk high phase. Without
// the macro, rb_crc is tied to zero and grid_sc_out is unused.

module rotfpga_cfg_loader #(
  parameter int CHAIN_LEN  = 512,
  parameter int RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        grid_clk,
  output logic        grid_rst_n,
  output logic        grid_se,
  output logic        grid_sc,
  output logic [1:0]  grid_cfg,
  input  logic        grid_sc_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] bit_count,
  output logic [7:0]  rb_crc
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRST      = 3'd1,
    WAIT_BYTE = 3'd2,
    SHIFT_LO  = 3'd3,
    SHIFT_HI  = 3'd4,
    FINISH    = 3'd5
  } state_t;

  localparam int              RCW         = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0]  RST_LAST    = RCW'(RST_CYCLES - 1);
  localparam logic [15:0]     CHAIN_LEN_W = 16'(CHAIN_LEN);

  state_t          state_q, state_d;
  logic [RCW-1:0]  rcnt_q, rcnt_d;
  logic [2:0]      bidx_q, bidx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [15:0]     bit_count_q, bit_count_d;
  logic [15:0]     bit_count_inc;
  logic            grid_clk_q, grid_clk_d;
  logic            grid_rst_n_q, grid_rst_n_d;
  logic            grid_se_q, grid_se_d;
  logic            grid_sc_q, grid_sc_d;
  logic [1:0]      grid_cfg_q, grid_cfg_d;

`ifdef ROTFPGA_CFG_READBACK_EN
  logic [7:0]      crc_q, crc_d;
  logic            crc_fb;
  assign crc_fb = crc_q[7] ^ grid_sc_out;
`endif

  // Saturating increment: the counter never wraps past CHAIN_LEN.
  assign bit_count_inc = (bit_count_q < CHAIN_LEN_W) ? bit_count_q + 16'd1 : bit_count_q;

  always_comb begin
    state_d     = state_q;
    rcnt_d      = rcnt_q;
    bidx_d      = bidx_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    grid_cfg_d  = grid_cfg_q;
`ifdef ROTFPGA_CFG_READBACK_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = GRST;
          grid_cfg_d  = cfg_mode;
          bit_count_d = 16'd0;
          rcnt_d      = '0;
`ifdef ROTFPGA_CFG_READBACK_EN
          crc_d       = 8'h00;
`endif
        end
      end
      GRST: begin
        if (rcnt_q == RST_LAST) begin
          state_d = WAIT_BYTE;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      WAIT_BYTE: begin
        if (byte_valid) begin
          shreg_d = byte_data;
          bidx_d  = 3'd0;
          state_d = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        state_d = SHIFT_HI;
      end
      SHIFT_HI: begin
        // The bit has been clocked into the grid on this high phase, so it
        // counts even if the load is aborted in this cycle.
        shreg_d     = {1'b0, shreg_q[7:1]};
        bit_count_d = bit_count_inc;
`ifdef ROTFPGA_CFG_READBACK_EN
        crc_d       = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);
`endif
        // Chain end wins over byte end, which drops unused upper bits.
        if (bit_count_inc == CHAIN_LEN_W) begin
          state_d = FINISH;
        end else if (bidx_q == 3'd7) begin
          state_d = WAIT_BYTE;
        end else begin
          bidx_d  = bidx_q + 3'd1;
          state_d = SHIFT_LO;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Grid pins are registered from the next state so that grid_clk is a clean
  // flop output and every pin changes together with the state.
  always_comb begin
    grid_clk_d   = (state_d == SHIFT_HI);
    grid_se_d    = (state_d == SHIFT_LO) || (state_d == SHIFT_HI);
    grid_rst_n_d = (state_d != GRST);
    grid_sc_d    = grid_sc_q;
    if (state_d == SHIFT_LO) begin
      grid_sc_d = shreg_d[0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rcnt_q       <= '0;
      bidx_q       <= 3'd0;
      shreg_q      <= 8'h00;
      bit_count_q  <= 16'd0;
      grid_clk_q   <= 1'b0;
      grid_rst_n_q <= 1'b1;
      grid_se_q    <= 1'b0;
      grid_sc_q    <= 1'b0;
      grid_cfg_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      bidx_q       <= bidx_d;
      shreg_q      <= shreg_d;
      bit_count_q  <= bit_count_d;
      grid_clk_q   <= grid_clk_d;
      grid_rst_n_q <= grid_rst_n_d;
      grid_se_q    <= grid_se_d;
      grid_sc_q    <= grid_sc_d;
      grid_cfg_q   <= grid_cfg_d;
    end
  end

`ifdef ROTFPGA_CFG_READBACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end
  assign rb_crc = crc_q;
`else
  logic unused_grid_sc_out;
  assign unused_grid_sc_out = grid_sc_out;
  assign rb_crc = 8'h00;
`endif

  // Status decodes come straight from the state flop. busy drops in the
  // FINISH cycle together with the done pulse.
  assign byte_ready = (state_q == WAIT_BYTE);
  assign busy       = (state_q != IDLE) && (state_q != FINISH);
  assign done       = (state_q == FINISH);
  assign bit_count  = bit_count_q;
  assign grid_clk   = grid_clk_q;
  assign grid_rst_n = grid_rst_n_q;
  assign grid_se    = grid_se_q;
  assign grid_sc    = grid_sc_q;
  assign grid_cfg   = grid_cfg_q;

endmodule
